// File: rtl/softreg_endpoint_pkg.sv
// softreg_endpoint_pkg: shell-wide soft-register channel types (package ShellTypes)
//   SoftRegReq               host request: valid, isWrite, addr (64-bit word index), data
//   SoftRegResp              read response: valid, data
//   SOFTREG_ERR_PATTERN      read data returned for out-of-range reads when SOFTREG_ERR_RESP_EN is defined
//   SOFTREG_MAX_READ_LATENCY largest supported response latency
package ShellTypes;
  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [63:0] addr;
    logic [63:0] data;
  } SoftRegReq;
  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;
  localparam logic [63:0] SOFTREG_ERR_PATTERN = 64'hDEAD_BEEF_DEAD_BEEF;
  localparam int unsigned SOFTREG_MAX_READ_LATENCY = 4;
endpackage

// File: rtl/softreg_endpoint_if.sv
// softreg_endpoint_if: SoftRegReq/SoftRegResp channel between shell (master) and role endpoint (slave)
//   softreg_req   request from the host side, no backpressure
//   softreg_resp  read response from the endpoint
interface softreg_endpoint_if;
  import ShellTypes::*;
  SoftRegReq  softreg_req;
  SoftRegResp softreg_resp;
  modport master (output softreg_req, input softreg_resp);
  modport slave (input softreg_req, output softreg_resp);
endinterface

// File: rtl/softreg_resp_pipe.sv
// softreg_resp_pipe: valid/data delay line of DEPTH registered stages with synchronous clear
//   clk, rst            clock, synchronous active-high clear of every stage
//   in_valid, in_data   response launched this cycle
//   out_valid, out_data response DEPTH cycles later; data is 0 whenever valid is 0
module softreg_resp_pipe #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] in_data,
  output logic        out_valid,
  output logic [63:0] out_data
);
  logic [DEPTH-1:0] v;
  logic [63:0]      d [DEPTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      v <= '0;
      for (int i = 0; i < int'(DEPTH); i++) d[i] <= '0;
    end else begin
      v[0] <= in_valid;
      d[0] <= in_valid ? in_data : '0;
      for (int i = 1; i < int'(DEPTH); i++) begin
        v[i] <= v[i-1];
        d[i] <= d[i-1];
      end
    end
  end
  assign out_valid = v[DEPTH-1];
  assign out_data  = d[DEPTH-1];
endmodule

// File: rtl/softreg_endpoint.sv
// softreg_endpoint: host soft-register responder with control bank, status word and cycle counter
//   clk, rst      shell clock, synchronous active-high reset
//   sr            SoftRegReq in / SoftRegResp out (slave modport)
//   status_in     read-only status word
//   reg_out       control registers, register i at [64*i +: 64]
//   reg_wr_pulse  one-cycle pulse per register the cycle after it is written
// Optional macro SOFTREG_ERR_RESP_EN: error pattern on out-of-range reads plus a
// saturating out-of-range access counter readable at idx NUM_REGS+2.
module softreg_endpoint
  import ShellTypes::*;
#(
  parameter int unsigned NUM_REGS     = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  softreg_endpoint_if.slave        sr,
  input  logic [63:0]              status_in,
  output logic [NUM_REGS*64-1:0]   reg_out,
  output logic [NUM_REGS-1:0]      reg_wr_pulse
);
  localparam logic [31:0] STAT_IDX = 32'(NUM_REGS);
  localparam logic [31:0] CNT_IDX  = STAT_IDX + 32'd1;
  SoftRegReq   req;
  logic [31:0] idx;
  logic        wr;
  logic        rd;
  logic        resp_valid;
  logic [63:0] cnt;
  logic [63:0] rd_data;
  logic [63:0] resp_data;
  logic        unused_addr_hi;
  assign req = sr.softreg_req;
  // a wrapping subtraction lands far above the map, so it decodes as out of range
  assign idx = req.addr[31:0] - BASE_ADDR;
  assign wr  = req.valid & req.isWrite;
  assign rd  = req.valid & ~req.isWrite;
  assign unused_addr_hi = ^req.addr[63:32];
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_out      <= '0;
      reg_wr_pulse <= '0;
      cnt          <= '0;
    end else begin
      cnt          <= (wr && idx == CNT_IDX) ? '0 : cnt + 64'd1;
      reg_wr_pulse <= '0;
      for (int i = 0; i < int'(NUM_REGS); i++) begin
        if (wr && idx == 32'(i)) begin
          reg_out[64*i +: 64] <= req.data;
          reg_wr_pulse[i]     <= 1'b1;
        end
      end
    end
  end
`ifdef SOFTREG_ERR_RESP_EN
  localparam logic [31:0] ERR_IDX = STAT_IDX + 32'd2;
  logic [15:0] err_cnt;
  always_ff @(posedge clk) begin
    if (rst) err_cnt <= '0;
    else err_cnt <= (wr && idx == ERR_IDX) ? '0 :
                    (req.valid && idx > ERR_IDX && err_cnt != '1) ? err_cnt + 16'd1 : err_cnt;
  end
`endif
  // read data is taken from the values visible in the request cycle
  always_comb begin
`ifdef SOFTREG_ERR_RESP_EN
    rd_data = SOFTREG_ERR_PATTERN;
`else
    rd_data = '0;
`endif
    for (int i = 0; i < int'(NUM_REGS); i++) if (idx == 32'(i)) rd_data = reg_out[64*i +: 64];
    if (idx == STAT_IDX) rd_data = status_in;
    if (idx == CNT_IDX) rd_data = cnt;
`ifdef SOFTREG_ERR_RESP_EN
    if (idx == ERR_IDX) rd_data = {48'h0, err_cnt};
`endif
  end
  softreg_resp_pipe #(.DEPTH(READ_LATENCY)) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (rd),
    .in_data   (rd_data),
    .out_valid (resp_valid),
    .out_data  (resp_data)
  );
  assign sr.softreg_resp = '{valid: resp_valid, data: resp_data};
endmodule

// File: tb/tb_softreg_endpoint.sv
// tb_softreg_endpoint: three endpoints (latency 2, 1, 4) on shared stimulus against a history-based model
module tb_softreg_endpoint;
  import ShellTypes::*;
  localparam int N = 16;
`ifdef SOFTREG_ERR_RESP_EN
  localparam logic [63:0] OOR_RD = 64'hDEAD_BEEF_DEAD_BEEF;
`else
  localparam logic [63:0] OOR_RD = 64'h0;
`endif
  typedef struct {
    logic        wr;
    logic [31:0] idx;
    logic [63:0] data;
    logic [63:0] exp;
  } vec_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  SoftRegReq   req = '0;
  logic [63:0] status = '0;
  int          lat_of [3] = '{2, 1, 4};
  SoftRegResp  rsp [3];
  logic [N*64-1:0] ro [3];
  logic [N-1:0]    pl [3];
  softreg_endpoint_if sr0 ();
  softreg_endpoint_if sr1 ();
  softreg_endpoint_if sr2 ();
  assign sr0.softreg_req = req;
  assign sr1.softreg_req = req;
  assign sr2.softreg_req = req;
  assign rsp[0] = sr0.softreg_resp;
  assign rsp[1] = sr1.softreg_resp;
  assign rsp[2] = sr2.softreg_resp;
  softreg_endpoint #(.NUM_REGS(N), .BASE_ADDR(32'h0), .READ_LATENCY(2)) dut0 (
    .clk(clk), .rst(rst), .sr(sr0), .status_in(status), .reg_out(ro[0]), .reg_wr_pulse(pl[0]));
  softreg_endpoint #(.NUM_REGS(N), .BASE_ADDR(32'h0), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .sr(sr1), .status_in(status), .reg_out(ro[1]), .reg_wr_pulse(pl[1]));
  softreg_endpoint #(.NUM_REGS(N), .BASE_ADDR(32'h0), .READ_LATENCY(4)) dut2 (
    .clk(clk), .rst(rst), .sr(sr2), .status_in(status), .reg_out(ro[2]), .reg_wr_pulse(pl[2]));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  // model: register image, counter as cycles since its last clear, and a per-cycle read history
  logic [63:0] m_regs [N];
  logic [15:0] m_err = '0;
  logic [N-1:0] m_pulse = '0;
  int clr = 0;
  int last_rst = -1;
  int cyc = 0;
  logic        hv [4096];
  logic [63:0] hd [4096];
  initial for (int r = 0; r < N; r++) m_regs[r] = '0;
  function automatic logic [63:0] m_read(input logic [31:0] i);
    if (i < N) return m_regs[i[3:0]];
    if (i == N) return status;
    if (i == N + 1) return 64'(cyc - clr);
`ifdef SOFTREG_ERR_RESP_EN
    if (i == N + 2) return {48'h0, m_err};
`endif
    return OOR_RD;
  endfunction
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        int s;
        logic ev;
        logic [63:0] ed;
        s = cyc - lat_of[d];
        ev = 1'b0;
        if (s >= 0) ev = hv[s] && last_rst < s;
        ed = ev ? hd[s] : 64'h0;
        chk($sformatf("sb_resp_valid_L%0d", lat_of[d]), 64'(rsp[d].valid), 64'(ev));
        chk($sformatf("sb_resp_data_L%0d", lat_of[d]), rsp[d].data, ed);
      end
      for (int r = 0; r < N; r++) chk($sformatf("sb_reg_out[%0d]", r), ro[0][64*r +: 64], m_regs[r]);
      chk("sb_reg_wr_pulse", 64'(pl[0]), 64'(m_pulse));
      begin
        logic [31:0] i;
        i = req.addr[31:0];
        if (rst) begin
          for (int r = 0; r < N; r++) m_regs[r] = '0;
          m_err = '0;
          m_pulse = '0;
          clr = cyc + 1;
          last_rst = cyc;
          hv[cyc] = 1'b0;
          hd[cyc] = '0;
        end else begin
          hv[cyc] = req.valid && !req.isWrite;
          hd[cyc] = m_read(i);
          m_pulse = '0;
          if (req.valid && req.isWrite) begin
            if (i < N) begin
              m_regs[i[3:0]] = req.data;
              m_pulse[i[3:0]] = 1'b1;
            end
            if (i == N + 1) clr = cyc + 1;
`ifdef SOFTREG_ERR_RESP_EN
            if (i == N + 2) m_err = '0;
`endif
          end
`ifdef SOFTREG_ERR_RESP_EN
          if (req.valid && i > N + 2 && m_err != 16'hFFFF) m_err = m_err + 16'd1;
`endif
        end
      end
      cyc++;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set(input logic v, input logic w, input logic [31:0] i, input logic [63:0] d);
    req.valid = v;
    req.isWrite = w;
    req.addr = {32'h0, i};
    req.data = d;
  endtask
  task automatic idle();
    set(1'b0, 1'b0, 32'h0, 64'h0);
  endtask
  vec_t tbl [$];
  initial begin
    tbl.push_back('{1'b1, 32'd5, 64'h0000_0000_0000_CAFE, 64'h0});
    tbl.push_back('{1'b0, 32'd5, 64'h0, 64'h0000_0000_0000_CAFE});
    tbl.push_back('{1'b1, 32'd15, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
    tbl.push_back('{1'b0, 32'd15, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    tbl.push_back('{1'b0, 32'd16, 64'h0, 64'hA5});
    tbl.push_back('{1'b1, 32'd16, 64'h1111, 64'h0});
    tbl.push_back('{1'b0, 32'd16, 64'h0, 64'hA5});
    tbl.push_back('{1'b0, 32'd100, 64'h0, OOR_RD});
`ifdef SOFTREG_ERR_RESP_EN
    tbl.push_back('{1'b0, 32'd18, 64'h0, 64'h1});
    tbl.push_back('{1'b1, 32'd18, 64'h0, 64'h0});
    tbl.push_back('{1'b0, 32'd18, 64'h0, 64'h0});
`else
    tbl.push_back('{1'b0, 32'd18, 64'h0, 64'h0});
`endif
    tbl.push_back('{1'b0, 32'hFFFF_FFFF, 64'h0, OOR_RD});
    rst = 1'b1;
    idle();
    repeat (2) tick();
    rst = 1'b0;
    chk("rst_resp_valid", 64'(rsp[0].valid), 64'h0);
    chk("rst_resp_data", rsp[0].data, 64'h0);
    chk("rst_reg_out_any", 64'(|ro[0]), 64'h0);
    chk("rst_reg_wr_pulse", 64'(pl[0]), 64'h0);
    set(1'b1, 1'b0, N + 1, 64'h0);
    tick();
    idle();
    tick();
    chk("first_cnt_valid", 64'(rsp[0].valid), 64'h1);
    chk("first_cnt_data", rsp[0].data, 64'h0);
    status = 64'hA5;
    foreach (tbl[k]) begin
      set(1'b1, tbl[k].wr, tbl[k].idx, tbl[k].data);
      tick();
      idle();
      tick();
      chk($sformatf("tbl%0d_valid", k), 64'(rsp[0].valid), 64'(!tbl[k].wr));
      chk($sformatf("tbl%0d_data", k), rsp[0].data, tbl[k].exp);
    end
    set(1'b1, 1'b1, 32'd3, 64'h1234_5678_9ABC_DEF0);
    tick();
    chk("raw_pulse", 64'(pl[0]), 64'h0008);
    chk("raw_reg_out3", ro[0][3*64 +: 64], 64'h1234_5678_9ABC_DEF0);
    set(1'b1, 1'b0, 32'd3, 64'h0);
    tick();
    idle();
    tick();
    chk("raw_resp_valid", 64'(rsp[0].valid), 64'h1);
    chk("raw_resp_data", rsp[0].data, 64'h1234_5678_9ABC_DEF0);
    for (int r = 0; r < 4; r++) begin
      set(1'b1, 1'b1, 32'(r), 64'(r + 1));
      tick();
    end
    idle();
    repeat (5) tick();
    for (int c = 0; c < 10; c++) begin
      if (c < 4) set(1'b1, 1'b0, 32'(c), 64'h0);
      else idle();
      for (int d = 0; d < 3; d++) begin
        int k;
        logic ev;
        k = c - lat_of[d];
        ev = k >= 0 && k < 4;
        chk($sformatf("b2b_valid_L%0d_c%0d", lat_of[d], c), 64'(rsp[d].valid), 64'(ev));
        chk($sformatf("b2b_data_L%0d_c%0d", lat_of[d], c), rsp[d].data, ev ? 64'(k + 1) : 64'h0);
      end
      tick();
    end
    set(1'b1, 1'b1, N + 1, 64'h0);
    tick();
    set(1'b1, 1'b0, N + 1, 64'h0);
    tick();
    idle();
    tick();
    chk("cnt_clr_valid", 64'(rsp[0].valid), 64'h1);
    chk("cnt_clr_data", rsp[0].data, 64'h0);
    repeat (5) tick();
    set(1'b1, 1'b0, 32'd0, 64'h0);
    tick();
    set(1'b1, 1'b0, 32'd1, 64'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    for (int c = 0; c < 6; c++) begin
      for (int d = 0; d < 3; d++) chk($sformatf("rst_drop_L%0d_c%0d", lat_of[d], c), 64'(rsp[d].valid), 64'h0);
      tick();
    end
    chk("rst_mid_reg_out_any", 64'(|ro[0]), 64'h0);
    for (int n = 0; n < 400; n++) begin
      int r;
      logic [31:0] i;
      rst = ($urandom_range(0, 63) == 0);
      status = {$urandom, $urandom};
      r = $urandom_range(0, 9);
      i = (r < 8) ? 32'($urandom_range(0, N + 3)) : (r == 8) ? 32'd100 : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      set($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, i, {$urandom, $urandom});
      tick();
    end
    rst = 1'b0;
    idle();
    repeat (8) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
